// File: rtl/imem_loader.sv
// imem_loader -- instruction-memory loader and core reset controller.
//
// Accepts a byte stream (valid/ready), parses a frame of the form
//   LEN_H, LEN_L, then N words sent high byte first,
// writes each 16-bit word into instruction memory through one write port,
// and holds the processor core in reset until the whole image is written.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   start          one-cycle pulse that begins (or restarts) a load
//   in_data        stream byte
//   in_valid       in_data is valid
//   in_ready       loader accepts a byte this cycle (decoded from state)
//   imem_we        instruction memory write strobe, one cycle per word
//   imem_addr      write address
//   imem_wdata     instruction word
//   cpu_rst        active-high reset to the processor core
//   done           program loaded, core running
//   err            frame length exceeded memory capacity (latched)
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    // Capacity in words; 17 bits so that ADDR_W = 16 still fits.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_INST_HI,
        S_INST_LO,
        S_RELEASE,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [15:0]         len_word;
    logic [15:0]         cnt_inc;

    // in_ready is the only output decoded straight from the state.
    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_INST_HI) || (state_q == S_INST_LO);
    assign accept   = in_valid && in_ready;
    assign len_word = {len_q[15:8], in_data};
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        we_d      = 1'b0;           // strobe is a single-cycle pulse
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                cpu_rst_d = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_word;
                    cnt_d = 16'd0;
                    if (len_word == 16'd0) begin
                        state_d = S_RELEASE;
                    end else if ({1'b0, len_word} > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_INST_HI;
                    end
                end
            end
            S_INST_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = S_INST_LO;
                end
            end
            S_INST_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    cnt_d   = cnt_inc;
                    // Compared against the full 16-bit length so N == DEPTH
                    // ends on address DEPTH-1 without wrapping.
                    state_d = (cnt_inc == len_q) ? S_RELEASE : S_INST_HI;
                end
            end
            S_RELEASE: begin
                // The last write strobe is visible during this cycle; the
                // core leaves reset on the following edge.
                state_d   = S_RUN;
                cpu_rst_d = 1'b0;
                done_d    = 1'b1;
            end
            S_RUN, S_ERR: begin
                if (start) begin
                    state_d   = S_LEN_HI;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed plus randomized bench for imem_loader.
// The reference model is a queue of expected (address, word) writes built
// from each frame's word list; every imem_we pulse must match the head.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int vectors    = 0;
    int miscompares = 0;

    int words[$];
    int bytes_q[$];
    int exp_addr_q[$];
    int exp_data_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, and any write
    // strobe is matched against the expected-write queue.
    task automatic tick();
        int a;
        int d;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_we", 32'(imem_we), 32'd0);
            end else begin
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                check("wr_addr", 32'(imem_addr), a);
                check("wr_data", 32'(imem_wdata), d);
                $display("write addr=%0h data=%04h", imem_addr, imem_wdata);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Builds the byte stream for length n from the word list, and the
    // expected writes when the length is legal.
    task automatic build_frame(input int n);
        bytes_q.delete();
        bytes_q.push_back((n >> 8) & 255);
        bytes_q.push_back(n & 255);
        foreach (words[i]) begin
            bytes_q.push_back((words[i] >> 8) & 255);
            bytes_q.push_back(words[i] & 255);
        end
        if (n > 0 && n <= DEPTH) begin
            foreach (words[i]) begin
                exp_addr_q.push_back(i);
                exp_data_q.push_back(words[i]);
            end
        end
    endtask

    // mode 0: full rate, 1: in_valid toggles every cycle,
    // 2: random valid, random garbage data, random ignored start pulses.
    task automatic send_bytes(input int count, input int mode);
        int  idx = 0;
        int  budget = 0;
        bit  phase = 1'b1;
        bit  acc;
        while (idx < count) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = phase;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? 8'(bytes_q[idx]) : 8'($urandom);
            start   = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            phase = ~phase;
            budget++;
            if (budget > 4000) begin
                check("send_timeout", 32'(idx), 32'(count));
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
        $display("frame sent: %0d bytes mode %0d", count, mode);
    endtask

    // Called right after the edge that accepted the final byte.
    task automatic check_release();
        check("rel_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rel_done", 32'(done), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_done", 32'(done), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd0);
        check("run_err", 32'(err), 32'd0);
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
        tick();
        check("run_hold_cpu_rst", 32'(cpu_rst), 32'd0);
    endtask

    task automatic run_frame(input int n, input int mode);
        build_frame(n);
        send_bytes(bytes_q.size(), mode);
        check_release();
    endtask

    initial begin
        int n;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Basic frame at full rate
        words = '{16'h1234, 16'hABCD};
        pulse_start();
        check("start_in_ready", 32'(in_ready), 32'd1);
        run_frame(2, 0);

        // Reload from RUN, same frame with toggling valid
        pulse_start();
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_in_ready", 32'(in_ready), 32'd1);
        run_frame(2, 1);

        // Zero length
        words.delete();
        pulse_start();
        run_frame(0, 0);

        // Oversize length -> ERR, then recover
        words.delete();
        pulse_start();
        build_frame(DEPTH + 1);
        send_bytes(2, 0);
        check("err_err", 32'(err), 32'd1);
        check("err_cpu_rst", 32'(cpu_rst), 32'd1);
        check("err_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("err_hold", 32'(err), 32'd1);
        check("err_hold_done", 32'(done), 32'd0);
        pulse_start();
        check("err_clear", 32'(err), 32'd0);
        check("err_restart_ready", 32'(in_ready), 32'd1);
        words = '{16'h1000};
        run_frame(1, 0);

        // Reload with FFFF
        words = '{16'hFFFF};
        pulse_start();
        check("reload2_cpu_rst", 32'(cpu_rst), 32'd1);
        run_frame(1, 0);

        // Reset in the middle of an 8-word frame, after 3 words
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back($urandom_range(0, 65535));
        pulse_start();
        build_frame(8);
        send_bytes(8, 0);
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_writes_made", 32'(exp_addr_q.size()), 32'd5);
        exp_addr_q.delete();
        exp_data_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("postrst_in_ready", 32'(in_ready), 32'd0);
        pulse_start();
        run_frame(8, 2);

        // Randomized frames with random gaps and ignored start pulses
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 12);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom_range(0, 65535));
            pulse_start();
            run_frame(n, 2);
        end

        // Random oversize length
        words.delete();
        n = $urandom_range(DEPTH + 1, 65535);
        pulse_start();
        build_frame(n);
        send_bytes(2, 2);
        check("rnd_err", 32'(err), 32'd1);
        check("rnd_err_cpu_rst", 32'(cpu_rst), 32'd1);

        // Full-capacity frame: last address DEPTH-1, no wrap
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom_range(0, 65535));
        pulse_start();
        run_frame(DEPTH, 0);
        check("full_last_addr", 32'(imem_addr), 32'(DEPTH - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the fetch stage's instruction-memory read path.
- Receives a byte stream over a valid/ready handshake and packs bytes into 16-bit instructions.
- Writes each instruction into instruction memory through a single write port.
- Holds the processor core in reset until the whole program image is loaded, then releases it. Sits beside the proc top level and drives its rst.

Parameters:
- ADDR_W, 8, instruction memory address width; capacity DEPTH = 2^ADDR_W words.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins (or restarts) a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  instruction word
- cpu_rst  out  1  reset to processor core, active-high
- done  out  1  program loaded, core running
- err  out  1  length error latched

Behaviour:
- Reset is asynchronous and active-high. It forces the following values:
  - state = IDLE, cpu_rst = 1
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - done = 0, err = 0, in_ready = 0
  - internal len = 0, cnt = 0, hi = 0
- All outputs are registered, except in_ready, which is decoded from the state.
- A byte is accepted on a cycle with in_valid && in_ready. Bytes are never dropped or duplicated. in_data is ignored when not accepted.
- Frame format: LEN_H, LEN_L (16-bit word count N, big-endian), then N words, each as high byte then low byte.
- State behaviour:
  - IDLE: in_ready=0, cpu_rst=1. start -> LEN_HI.
  - LEN_HI: in_ready=1. On accept, store len[15:8] -> LEN_LO.
  - LEN_LO: in_ready=1. On accept, form the full length and set cnt=0, then:
    - N == 0 -> RELEASE
    - N > DEPTH -> ERR
    - otherwise -> INST_HI
  - INST_HI: in_ready=1. On accept, hi <= byte -> INST_LO.
  - INST_LO: in_ready=1. On accept, the next cycle shows imem_we=1, imem_addr=cnt[ADDR_W-1:0], imem_wdata={hi,byte}. cnt increments. If cnt+1 == N -> RELEASE, else -> INST_HI.
  - RELEASE: in_ready=0. Exactly one cycle; cpu_rst still 1 -> RUN.
  - RUN: cpu_rst=0, done=1, in_ready=0.
  - ERR: err=1, cpu_rst=1, in_ready=0.
- imem_we is a single-cycle pulse. It is 0 in every cycle not immediately following an INST_LO accept.
- Back-to-back full-rate input writes one word every 2 cycles.
- Timing of the last word: the last imem_we pulse coincides with the RELEASE cycle. cpu_rst falls on the following edge, so it is low 2 cycles after the final byte is accepted.
- start in RUN or ERR:
  - Next state is LEN_HI.
  - cpu_rst=1 on that same edge; done=0, err=0.
  - imem_addr is not cleared; cnt restarts at 0.
- start in LEN_HI..INST_LO or RELEASE: ignored (no restart mid-frame).
- start and a byte accept in the same cycle: the accept wins; start is ignored.
- N == DEPTH is legal. The last address is DEPTH-1, and imem_addr never wraps during a legal load.
- cnt is 16-bit and is compared against the full 16-bit N.
- rst asserted mid-load: immediate return to the reset values. cpu_rst=1. The partially written memory is not cleared.
- imem_we from a load interrupted by rst is suppressed asynchronously.

Test Plan:
- Reset then start, stream 00 02 12 34 AB CD at full rate:
  - imem writes (0,1234h) then (1,ABCDh)
  - cpu_rst drops 2 cycles after the final byte accept
  - done=1
- Same frame with in_valid toggled 1/0 every cycle: identical writes and addresses, no extra imem_we pulses.
- Length 0 (bytes 00 00): no imem_we, RELEASE then RUN, cpu_rst=0 exactly 2 cycles after the LEN_L accept.
- ADDR_W=8, length 0101h (257): ERR entered after LEN_L, err=1, cpu_rst stays 1, in_ready=0. Then start clears err and a valid frame 00 01 10 00 writes (0,1000h).
- Reload:
  - In RUN, pulse start: cpu_rst rises and done falls on the next edge.
  - Load 00 01 FF FF: write (0,FFFFh), re-release.
- rst asserted after 3 words of an 8-word frame:
  - cpu_rst=1, imem_we=0 immediately, state IDLE, in_ready=0.
  - A later start with a full frame loads correctly from address 0.
